// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-byte ingress, consumer ready/valid egress and status of the rx FIFO
interface uart_rx_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0]          din;
  logic                din_vld;
  logic                frame_error;
  logic                parity_error;
  logic                flush;
  logic                clr_err;
  logic [7:0]          dout;
  logic                dout_vld;
  logic                dout_rdy;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic [7:0]          err_cnt;
  modport master (
    output din, din_vld, frame_error, parity_error, flush, clr_err, dout_rdy,
    input  dout, dout_vld, full, empty, level, overflow, err_cnt
  );
  modport slave (
    input  din, din_vld, frame_error, parity_error, flush, clr_err, dout_rdy,
    output dout, dout_vld, full, empty, level, overflow, err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind the UART receiver with sticky overflow and saturating error count
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  r_ovf;
  logic [7:0]            r_err_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_err;
  always_comb begin
    w_full  = r_cnt == (DEPTH_LOG2+1)'(DEPTH);
    w_empty = r_cnt == '0;
    w_pop   = !w_empty && bus.dout_rdy;
    w_push  = bus.din_vld && (!w_full || w_pop);
    w_drop  = bus.din_vld && w_full && !w_pop && !bus.flush;
    w_err   = bus.frame_error || bus.parity_error;
  end
  always_ff @(posedge i_clk)
    if (w_push && !bus.flush) r_mem[r_wr_ptr] <= bus.din;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + DEPTH_LOG2'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + DEPTH_LOG2'(1) : r_rd_ptr;
      r_cnt    <= (w_push && !w_pop) ? r_cnt + (DEPTH_LOG2+1)'(1) :
                  (w_pop && !w_push) ? r_cnt - (DEPTH_LOG2+1)'(1) : r_cnt;
    end
  end
  // a new error event in the same cycle as CLR_ERR takes precedence over the clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ovf     <= w_drop ? 1'b1 : bus.clr_err ? 1'b0 : r_ovf;
      r_err_cnt <= bus.clr_err ? (w_err ? 8'd1 : 8'd0) :
                   (w_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
    end
  end
  always_comb begin
    bus.dout     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    bus.dout_vld = !w_empty;
    bus.full     = w_full;
    bus.empty    = w_empty;
    bus.level    = r_cnt;
    bus.overflow = r_ovf;
    bus.err_cnt  = r_err_cnt;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven bench for uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 1 << DL;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // one clock: score the pop and level against the reference queue, then advance
  task automatic tick();
    logic pop, push;
    logic [7:0] e;
    pop  = bus.dout_vld && bus.dout_rdy && !bus.flush;
    push = bus.din_vld && !bus.flush && (exp_q.size() < DEPTH || pop);
    n_cmp++;
    if (bus.level !== (DL+1)'(exp_q.size())) begin
      n_err++;
      $display("FAIL level: got %0d expected %0d", bus.level, exp_q.size());
    end
    if (pop) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %h expected none", bus.dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e) begin
          n_err++;
          $display("FAIL dout_order: got %h expected %h", bus.dout, e);
        end
      end
    end
    if (bus.flush) exp_q.delete();
    if (push) exp_q.push_back(bus.din);
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] base, input int n);
    bus.din_vld = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.din = base + 8'(i);
      tick();
    end
    bus.din_vld = 1'b0;
  endtask
  task automatic drain(input int n);
    bus.dout_rdy = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.dout_rdy = 1'b0;
  endtask
  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.empty, bus.full, bus.dout_vld, bus.overflow} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 1000", {bus.empty, bus.full, bus.dout_vld, bus.overflow});
    end
    n_cmp++;
    if (bus.dout !== 8'h00 || bus.err_cnt !== 8'h00 || bus.level !== '0) begin
      n_err++;
      $display("FAIL reset_values: got dout %h err %h level %0d expected 00 00 0", bus.dout, bus.err_cnt, bus.level);
    end
  endtask
  task automatic test_basic();
    bus.din_vld = 1'b1;
    bus.din = 8'hA5; tick();
    bus.din = 8'h3C; tick();
    bus.din = 8'h7E; tick();
    bus.din_vld = 1'b0;
    n_cmp++;
    if (bus.level !== 5'd3 || bus.dout !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_head: got level %0d dout %h expected 3 a5", bus.level, bus.dout);
    end
    drain(3);
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL basic_empty: got empty %b dout %h expected 1 00", bus.empty, bus.dout);
    end
  endtask
  task automatic test_overflow();
    fill(8'h00, DEPTH);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16) begin
      n_err++;
      $display("FAIL full: got full %b level %0d expected 1 16", bus.full, bus.level);
    end
    fill(8'hFF, 1);
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin
      n_err++;
      $display("FAIL overflow: got ovf %b level %0d expected 1 16", bus.overflow, bus.level);
    end
    drain(DEPTH);
    n_cmp++;
    if (bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_drain: got empty %b expected 1", bus.empty);
    end
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clr_overflow: got %b expected 0", bus.overflow);
    end
  endtask
  task automatic test_full_push_pop();
    fill(8'h20, DEPTH);
    bus.dout_rdy = 1'b1;
    bus.din_vld = 1'b1;
    bus.din = 8'h55;
    tick();
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.level !== 5'd16) begin
      n_err++;
      $display("FAIL full_pushpop: got ovf %b level %0d expected 0 16", bus.overflow, bus.level);
    end
    for (int i = 0; i < 40; i++) begin
      bus.din = 8'h60 + 8'(i);
      tick();
    end
    bus.din_vld = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_pushpop: got ovf %b full %b expected 0 1", bus.overflow, bus.full);
    end
    drain(DEPTH);
  endtask
  task automatic test_err_cnt();
    for (int i = 0; i < 300; i++) begin
      bus.frame_error = (i % 3) != 1;
      bus.parity_error = (i % 3) != 0;
      tick();
      if (i == 99) begin
        n_cmp++;
        if (bus.err_cnt !== 8'd100) begin
          n_err++;
          $display("FAIL err_count: got %0d expected 100", bus.err_cnt);
        end
      end
    end
    bus.frame_error = 1'b0;
    bus.parity_error = 1'b0;
    n_cmp++;
    if (bus.err_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL err_saturate: got %h expected ff", bus.err_cnt);
    end
    bus.clr_err = 1'b1; tick();
    n_cmp++;
    if (bus.err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL err_clear: got %h expected 00", bus.err_cnt);
    end
    bus.frame_error = 1'b1; tick();
    bus.clr_err = 1'b0;
    bus.frame_error = 1'b0;
    n_cmp++;
    if (bus.err_cnt !== 8'h01) begin
      n_err++;
      $display("FAIL err_clear_event: got %h expected 01", bus.err_cnt);
    end
  endtask
  task automatic test_flush();
    fill(8'h80, DEPTH + 1);
    drain(11);
    n_cmp++;
    if (bus.level !== 5'd5 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flush_setup: got level %0d ovf %b expected 5 1", bus.level, bus.overflow);
    end
    bus.flush = 1'b1;
    bus.din_vld = 1'b1;
    bus.din = 8'h99;
    bus.dout_rdy = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.din_vld = 1'b0;
    bus.dout_rdy = 1'b0;
    n_cmp++;
    if (bus.level !== '0 || bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flush: got level %0d empty %b ovf %b expected 0 1 1", bus.level, bus.empty, bus.overflow);
    end
    fill(8'h42, 1);
    drain(1);
  endtask
  task automatic test_async_reset();
    fill(8'h70, 7);
    n_cmp++;
    if (bus.level !== 5'd7 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL areset_setup: got level %0d ovf %b expected 7 1", bus.level, bus.overflow);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.level !== '0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.dout_vld !== 1'b0 || bus.dout !== 8'h00 || bus.err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL areset: got level %0d empty %b ovf %b vld %b dout %h err %h expected 0 1 0 0 00 00",
               bus.level, bus.empty, bus.overflow, bus.dout_vld, bus.dout, bus.err_cnt);
    end
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    fill(8'h11, 1);
    n_cmp++;
    if (bus.dout !== 8'h11 || bus.level !== 5'd1) begin
      n_err++;
      $display("FAIL areset_head: got dout %h level %0d expected 11 1", bus.dout, bus.level);
    end
    drain(1);
  endtask
  initial begin
    bus.din = 8'h00;
    bus.din_vld = 1'b0;
    bus.frame_error = 1'b0;
    bus.parity_error = 1'b0;
    bus.flush = 1'b0;
    bus.clr_err = 1'b0;
    bus.dout_rdy = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_err_cnt();
    test_flush();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
